// File: rtl/sd_command.sv
// sd_command: SPI-mode SD card command engine.
//   Sends a 48-bit command frame (cmd_number, cmd_args, cmd_crc) MSB first on D1.
//   It then waits for the R1 byte on D0.
//   CMD8 and CMD58 get a 32-bit trailer, which is captured into response_data.
//   CMD17 with R1=0x00 waits for the 0xFE start token, then captures the
//   4-byte data block and discards the 16-bit CRC.
//   Every transaction ends with 8 clocks with CS high and D1 high, then a
//   one-cycle done pulse.
// Ports:
//   clk, reset             bit clock; synchronous active-high reset
//   start                  level request, held until done (held high = retry)
//   cmd_number/args/crc    command frame fields, latched when start is accepted
//   done                   one-cycle completion pulse
//   response_flags/data    R1 byte and trailing 32 bits of the last transaction
//   D0 / D1 / CS           card MISO / MOSI / chip select (active low)

// Generic holding register: synchronous reset to 0, loads when Load=1.
module register #(
    parameter int N = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load,
    input  logic [N-1:0] D_In,
    output logic [N-1:0] D_Out
);
    always_ff @(posedge Clk) begin
        if (Reset)     D_Out <= '0;
        else if (Load) D_Out <= D_In;
    end
endmodule

module sd_command #(
    parameter int NCR_MAX   = 16,    // R1 wait limit, in bytes
    parameter int TOKEN_MAX = 1024   // data token wait limit, in bits
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cmd_number,
    input  logic [31:0] cmd_args,
    input  logic [7:0]  cmd_crc,
    output logic        done,
    output logic [7:0]  response_flags,
    output logic [31:0] response_data,
    input  logic        D0,
    output logic        D1,
    output logic        CS
);
    localparam int R1_WAIT = NCR_MAX * 8;
    localparam int CNT_A   = (R1_WAIT > TOKEN_MAX) ? R1_WAIT : TOKEN_MAX;
    localparam int CNT_MAX = (CNT_A > 48) ? CNT_A : 48;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [3:0] {
        S_IDLE, S_SEND, S_WAIT_R1, S_READ_R1, S_READ_EXT,
        S_WAIT_TOKEN, S_READ_DATA, S_READ_CRC, S_TRAIL, S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [7:0]       tok_sr, tok_nx;

    logic [47:0] frame_q;
    logic        frame_ld;
    logic        data_ld, flags_ld;
    logic [31:0] data_d;
    logic [7:0]  flags_d, flags_n_q;
    logic [5:0]  bit_idx;
    logic [7:0]  r1_shift, tok_shift;
    logic [31:0] data_shift;
    logic [7:0]  cmd_q;

    // Latched command frame; reused bit-by-bit during SEND.
    register #(.N(48)) u_frame (
        .Clk(clk), .Reset(reset), .Load(frame_ld),
        .D_In({cmd_number, cmd_args, cmd_crc}), .D_Out(frame_q)
    );

    register #(.N(32)) u_data (
        .Clk(clk), .Reset(reset), .Load(data_ld),
        .D_In(data_d), .D_Out(response_data)
    );

    // The register resets to 0, but the flags must read 0xFF after reset.
    // The flags are therefore stored inverted.
    register #(.N(8)) u_flags (
        .Clk(clk), .Reset(reset), .Load(flags_ld),
        .D_In(~flags_d), .D_Out(flags_n_q)
    );
    assign response_flags = ~flags_n_q;

    assign cmd_q      = frame_q[47:40];
    assign bit_idx    = 6'd47 - cnt[5:0];
    assign r1_shift   = {response_flags[6:0], D0};
    assign tok_shift  = {tok_sr[6:0], D0};
    assign data_shift = {response_data[30:0], D0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            tok_sr <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            tok_sr <= tok_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        tok_nx   = tok_sr;
        frame_ld = 1'b0;
        data_ld  = 1'b0;
        data_d   = response_data;
        flags_ld = 1'b0;
        flags_d  = response_flags;
        CS       = 1'b0;
        D1       = 1'b1;
        done     = 1'b0;

        case (state)
            S_IDLE: begin
                CS     = 1'b1;
                cnt_nx = '0;
                if (start) begin
                    state_nx = S_SEND;
                    frame_ld = 1'b1;
                    flags_ld = 1'b1;
                    flags_d  = 8'hFF;
                    data_ld  = 1'b1;
                    data_d   = 32'h0;
                end
            end
            S_SEND: begin
                D1 = frame_q[bit_idx];
                if (cnt == CNT_W'(47)) begin
                    state_nx = S_WAIT_R1;
                    cnt_nx   = '0;
                end
            end
            S_WAIT_R1: begin
                if (!D0) begin
                    // The first 0 bit is R1 bit 7. Shifting it into 0xFF
                    // leaves the flags correct after 7 more shifts.
                    flags_ld = 1'b1;
                    flags_d  = r1_shift;
                    state_nx = S_READ_R1;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(R1_WAIT - 1)) begin
                    flags_ld = 1'b1;
                    flags_d  = 8'hFF;
                    data_ld  = 1'b1;
                    data_d   = 32'hFFFF_FFFF;
                    state_nx = S_TRAIL;
                    cnt_nx   = '0;
                end
            end
            S_READ_R1: begin
                flags_ld = 1'b1;
                flags_d  = r1_shift;
                if (cnt == CNT_W'(6)) begin
                    cnt_nx = '0;
                    if (cmd_q == 8'h48 || cmd_q == 8'h7A)
                        state_nx = S_READ_EXT;
                    else if (cmd_q == 8'h51 && r1_shift == 8'h00) begin
                        state_nx = S_WAIT_TOKEN;
                        tok_nx   = 8'hFF;  // flush so R1 zeros cannot fake a token
                    end else
                        state_nx = S_TRAIL;
                end
            end
            S_READ_EXT: begin
                data_ld = 1'b1;
                data_d  = data_shift;
                if (cnt == CNT_W'(31)) begin
                    state_nx = S_TRAIL;
                    cnt_nx   = '0;
                end
            end
            S_WAIT_TOKEN: begin
                tok_nx = tok_shift;
                if (tok_shift == 8'hFE) begin
                    state_nx = S_READ_DATA;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(TOKEN_MAX - 1)) begin
                    data_ld  = 1'b1;
                    data_d   = 32'hFFFF_FFFF;
                    state_nx = S_TRAIL;
                    cnt_nx   = '0;
                end
            end
            S_READ_DATA: begin
                data_ld = 1'b1;
                data_d  = data_shift;
                if (cnt == CNT_W'(31)) begin
                    state_nx = S_READ_CRC;
                    cnt_nx   = '0;
                end
            end
            S_READ_CRC: begin
                if (cnt == CNT_W'(15)) begin
                    state_nx = S_TRAIL;
                    cnt_nx   = '0;
                end
            end
            S_TRAIL: begin
                CS = 1'b1;
                if (cnt == CNT_W'(7)) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end
            end
            S_DONE: begin
                CS       = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_sd_command.sv
// Directed bench for sd_command: a scripted card feeds D0, and the bench
// captures the D1 frame. It checks the done timing and the response registers.
module tb_sd_command;
    logic        clk = 1'b0;
    logic        reset, start, D0;
    logic [7:0]  cmd_number, cmd_crc;
    logic [31:0] cmd_args;
    logic        done, D1, CS;
    logic [7:0]  response_flags;
    logic [31:0] response_data;

    always #5 clk = ~clk;

    sd_command dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_number(cmd_number), .cmd_args(cmd_args), .cmd_crc(cmd_crc),
        .done(done), .response_flags(response_flags), .response_data(response_data),
        .D0(D0), .D1(D1), .CS(CS)
    );

    int errors = 0;
    int checks = 0;
    bit resp_q[$];

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) resp_q.push_back(b[i]);
    endtask

    // Called at a negedge with the DUT idle. The next posedge is the start
    // edge, and cycle n is the one ending at the n-th edge after it.
    // Card bits are sampled from edge 49 onward.
    task automatic run_txn(input logic [7:0] cmd, input logic [31:0] args,
                           input logic [7:0] crc, input bit hold,
                           output int done_cyc, output logic [47:0] sent);
        cmd_number = cmd;
        cmd_args   = args;
        cmd_crc    = crc;
        start      = 1'b1;
        done_cyc   = -1;
        sent       = '1;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (n == 1) check("cs_low_send", {47'd0, CS}, 48'd0);
            if (n <= 48) sent[48-n] = D1;
            if (done) begin
                done_cyc = n;
                break;
            end
            if (n >= 49 && resp_q.size() > 0) D0 = resp_q.pop_front();
            else D0 = 1'b1;
        end
        D0 = 1'b1;
        @(negedge clk);
        check("done_one_cycle", {47'd0, done}, 48'd0);
        check("cs_idle", {47'd0, CS}, 48'd1);
    endtask

    int          dc;
    logic [47:0] fr;

    initial begin
        reset = 1'b1; start = 1'b0; D0 = 1'b1;
        cmd_number = '0; cmd_args = '0; cmd_crc = '0;
        repeat (3) @(negedge clk);
        check("rst_cs",    {47'd0, CS}, 48'd1);
        check("rst_d1",    {47'd0, D1}, 48'd1);
        check("rst_done",  {47'd0, done}, 48'd0);
        check("rst_flags", {40'd0, response_flags}, 48'hFF);
        check("rst_data",  {16'd0, response_data}, 48'h0);
        reset = 1'b0;
        @(negedge clk);

        // CMD0: two idle bytes then R1=0x01
        resp_q.delete(); push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h01);
        run_txn(8'h40, 32'h0, 8'h95, 1'b0, dc, fr);
        check("cmd0_frame", fr, 48'h40_00000000_95);
        check("cmd0_done_at", 48'(dc), 48'd81);
        check("cmd0_flags", {40'd0, response_flags}, 48'h01);
        check("cmd0_data",  {16'd0, response_data}, 48'h0);

        // CMD8: R1 then 32-bit R7 payload
        resp_q.delete(); push_byte(8'h01);
        push_byte(8'h00); push_byte(8'h00); push_byte(8'h01); push_byte(8'hAA);
        run_txn(8'h48, 32'h0000_01AA, 8'h87, 1'b0, dc, fr);
        check("cmd8_frame", fr, 48'h48_000001AA_87);
        check("cmd8_done_at", 48'(dc), 48'd97);
        check("cmd8_flags", {40'd0, response_flags}, 48'h01);
        check("cmd8_data",  {16'd0, response_data}, 48'h0000_01AA);

        // CMD17: R1=0x00, 3 idle bytes, token, 4 data bytes, 2 CRC bytes
        resp_q.delete(); push_byte(8'h00);
        push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFF); push_byte(8'hFE);
        push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
        push_byte(8'h12); push_byte(8'h34);
        run_txn(8'h51, 32'h0000_0010, 8'hFF, 1'b0, dc, fr);
        check("cmd17_done_at", 48'(dc), 48'd145);
        check("cmd17_flags", {40'd0, response_flags}, 48'h00);
        check("cmd17_data",  {16'd0, response_data}, 48'hDEAD_BEEF);

        // CMD17 with a nonzero R1 skips the data phase
        resp_q.delete(); push_byte(8'h04);
        run_txn(8'h51, 32'h0000_0010, 8'hFF, 1'b0, dc, fr);
        check("cmd17err_done_at", 48'(dc), 48'd65);
        check("cmd17err_flags", {40'd0, response_flags}, 48'h04);
        check("cmd17err_data",  {16'd0, response_data}, 48'h0);

        // R1 timeout: D0 stays high
        resp_q.delete();
        run_txn(8'h40, 32'h0, 8'h95, 1'b0, dc, fr);
        check("r1to_done_at", 48'(dc), 48'd185);
        check("r1to_flags", {40'd0, response_flags}, 48'hFF);
        check("r1to_data",  {16'd0, response_data}, 48'hFFFF_FFFF);

        // Token timeout: R1=0x00, then no token
        resp_q.delete(); push_byte(8'h00);
        run_txn(8'h51, 32'h0000_0020, 8'hFF, 1'b0, dc, fr);
        check("tokto_done_at", 48'(dc), 48'd1089);
        check("tokto_flags", {40'd0, response_flags}, 48'h00);
        check("tokto_data",  {16'd0, response_data}, 48'hFFFF_FFFF);

        // ACMD41 retry loop with start held: R1 0x01, 0x01, then 0x00
        resp_q.delete(); push_byte(8'h01);
        run_txn(8'h69, 32'h4000_0000, 8'h77, 1'b1, dc, fr);
        check("acmd41_1_done_at", 48'(dc), 48'd65);
        check("acmd41_1_flags", {40'd0, response_flags}, 48'h01);
        resp_q.delete(); push_byte(8'h01);
        run_txn(8'h69, 32'h4000_0000, 8'h77, 1'b1, dc, fr);
        check("acmd41_2_done_at", 48'(dc), 48'd65);
        check("acmd41_2_frame", fr, 48'h69_40000000_77);
        resp_q.delete(); push_byte(8'h00);
        run_txn(8'h69, 32'h4000_0000, 8'h77, 1'b0, dc, fr);
        check("acmd41_3_done_at", 48'(dc), 48'd65);
        check("acmd41_3_flags", {40'd0, response_flags}, 48'h00);
        repeat (3) @(negedge clk);
        check("acmd41_stop", {46'd0, CS, done}, 48'b10);

        // Reset asserted during bit 20 of SEND
        cmd_number = 8'h40; cmd_args = 32'h0; cmd_crc = 8'h95; start = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 21) begin
                check("pre_rst_cs", {47'd0, CS}, 48'd0);
                reset = 1'b1;
            end
        end
        @(negedge clk);
        check("mid_rst_cs",    {47'd0, CS}, 48'd1);
        check("mid_rst_d1",    {47'd0, D1}, 48'd1);
        check("mid_rst_flags", {40'd0, response_flags}, 48'hFF);
        check("mid_rst_done",  {47'd0, done}, 48'd0);
        reset = 1'b0;
        @(negedge clk);
        resp_q.delete(); push_byte(8'h01);
        run_txn(8'h40, 32'h0, 8'h95, 1'b0, dc, fr);
        check("post_rst_frame", fr, 48'h40_00000000_95);
        check("post_rst_done_at", 48'(dc), 48'd65);
        check("post_rst_flags", {40'd0, response_flags}, 48'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
